// File: rtl/axi_std_master.sv
// axi_std_master: single-command AXI4 INCR burst initiator.
// A write drives AW, streams source beats onto W and collects B.
// A read drives AR and forwards R beats to a sink.
// The W and R data paths are pass-through and are gated to 0 outside their data states.
module axi_std_master #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_M_AXI_ADDR_WIDTH = 6
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  // command interface
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_rnw,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [7:0]                        cmd_len,
  // write source
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     wr_data,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  // read sink
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rd_data,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic                              rd_last,
  // status
  output logic                              busy,
  output logic                              done,
  output logic                              resp_err,
  // AW channel
  output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [7:0]                        M_AXI_AWLEN,
  output logic [2:0]                        M_AXI_AWSIZE,
  output logic [1:0]                        M_AXI_AWBURST,
  output logic                              M_AXI_AWLOCK,
  output logic [3:0]                        M_AXI_AWCACHE,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic [3:0]                        M_AXI_AWQOS,
  output logic [3:0]                        M_AXI_AWREGION,
  output logic [0:0]                        M_AXI_AWUSER,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  // W channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WLAST,
  output logic [0:0]                        M_AXI_WUSER,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  // B channel
  input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_BID,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  // AR channel
  output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [7:0]                        M_AXI_ARLEN,
  output logic [2:0]                        M_AXI_ARSIZE,
  output logic [1:0]                        M_AXI_ARBURST,
  output logic                              M_AXI_ARLOCK,
  output logic [3:0]                        M_AXI_ARCACHE,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic [3:0]                        M_AXI_ARQOS,
  output logic [3:0]                        M_AXI_ARREGION,
  output logic [0:0]                        M_AXI_ARUSER,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  // R channel
  input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RLAST,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  // Full-width beats: AxSIZE encodes log2 of the bus width in bytes.
  localparam logic [2:0] AXSIZE = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5
  } state_e;

  state_e                          state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]                      len_q, len_d;
  logic [7:0]                      cnt_q, cnt_d;
  logic                            done_q, done_d;
  logic                            err_q, err_d;

  logic                            wr_st_s;
  logic                            rd_st_s;
  logic                            last_s;
  logic                            w_hs_s;
  logic                            r_hs_s;
  logic                            unused_s;

  assign wr_st_s  = (state_q == WR_DATA);
  assign rd_st_s  = (state_q == RD_DATA);
  assign last_s   = (cnt_q == len_q);
  assign w_hs_s   = wr_st_s && wr_valid && M_AXI_WREADY;
  assign r_hs_s   = rd_st_s && M_AXI_RVALID && rd_ready;
  // Response IDs carry no information since every request uses ID 0.
  assign unused_s = ^{M_AXI_BID, M_AXI_RID};

  // State and datapath registers with synchronous reset.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: command latch, beat counting, error accumulation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = cmd_rnw ? RD_ADDR : WR_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      WR_ADDR: begin
        if (M_AXI_AWREADY) begin
          state_d = WR_DATA;
        end else begin
          state_d = WR_ADDR;
        end
      end
      WR_DATA: begin
        if (w_hs_s) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = last_s ? WR_RESP : WR_DATA;
        end else begin
          state_d = WR_DATA;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          err_d   = err_q | (M_AXI_BRESP != 2'b00);
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WR_RESP;
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          state_d = RD_DATA;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (r_hs_s) begin
          cnt_d = cnt_q + 8'd1;
          err_d = err_q | (M_AXI_RRESP != 2'b00) | (M_AXI_RLAST != last_s);
          // The local beat count, not RLAST, decides where the burst ends.
          if (last_s) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RD_DATA;
          end
        end else begin
          state_d = RD_DATA;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs
  assign cmd_ready = (state_q == IDLE) && !M_AXI_ARESET;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign resp_err  = err_q;

  // AW channel: fields come straight from the command latch, so they stay stable until AWREADY.
  assign M_AXI_AWID     = '0;
  assign M_AXI_AWADDR   = addr_q;
  assign M_AXI_AWLEN    = len_q;
  assign M_AXI_AWSIZE   = AXSIZE;
  assign M_AXI_AWBURST  = 2'b01;
  assign M_AXI_AWLOCK   = 1'b0;
  assign M_AXI_AWCACHE  = 4'd0;
  assign M_AXI_AWPROT   = 3'd0;
  assign M_AXI_AWQOS    = 4'd0;
  assign M_AXI_AWREGION = 4'd0;
  assign M_AXI_AWUSER   = 1'b0;
  assign M_AXI_AWVALID  = (state_q == WR_ADDR);

  // W channel: pass-through from the source, only while streaming data.
  assign M_AXI_WDATA  = wr_st_s ? wr_data : '0;
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_WLAST  = wr_st_s && last_s;
  assign M_AXI_WUSER  = 1'b0;
  assign M_AXI_WVALID = wr_st_s && wr_valid;
  assign wr_ready     = wr_st_s && M_AXI_WREADY;

  // B channel
  assign M_AXI_BREADY = (state_q == WR_RESP);

  // AR channel
  assign M_AXI_ARID     = '0;
  assign M_AXI_ARADDR   = addr_q;
  assign M_AXI_ARLEN    = len_q;
  assign M_AXI_ARSIZE   = AXSIZE;
  assign M_AXI_ARBURST  = 2'b01;
  assign M_AXI_ARLOCK   = 1'b0;
  assign M_AXI_ARCACHE  = 4'd0;
  assign M_AXI_ARPROT   = 3'd0;
  assign M_AXI_ARQOS    = 4'd0;
  assign M_AXI_ARREGION = 4'd0;
  assign M_AXI_ARUSER   = 1'b0;
  assign M_AXI_ARVALID  = (state_q == RD_ADDR);

  // R channel: pass-through to the sink, only while receiving data.
  assign M_AXI_RREADY = rd_st_s && rd_ready;
  assign rd_valid     = rd_st_s && M_AXI_RVALID;
  assign rd_data      = rd_st_s ? M_AXI_RDATA : '0;
  assign rd_last      = rd_st_s && last_s;

endmodule

// File: tb/tb_axi_std_master.sv
// Directed bench for axi_std_master with a small reactive AXI slave model.
module tb_axi_std_master;
  localparam int DW = 512;
  localparam int AW = 6;
  localparam int IW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic cmd_valid, cmd_ready, cmd_rnw;
  logic [AW-1:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [DW-1:0] wr_data, rd_data;
  logic wr_valid, wr_ready, rd_valid, rd_ready, rd_last;
  logic busy, done, resp_err;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock;
  logic [3:0] awcache, arcache, awqos, arqos, awregion, arregion;
  logic [0:0] awuser, aruser, wuser;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;

  axi_std_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .busy(busy), .done(done), .resp_err(resp_err),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
    .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWREGION(awregion),
    .M_AXI_AWUSER(awuser), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WUSER(wuser),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARREGION(arregion),
    .M_AXI_ARUSER(aruser), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // ---------------- slave model ----------------
  logic [1:0] cfg_bresp = 2'b00;
  logic       cfg_early = 1'b0;
  logic s_aw_rdy, s_w_open, s_w_rdy, s_bvalid, s_ar_rdy, s_r_act;
  logic [7:0] s_r_cnt, s_r_len;
  logic [DW-1:0] rmem [8];

  assign awready = s_aw_rdy;
  assign wready  = s_w_rdy;
  assign bvalid  = s_bvalid;
  assign bresp   = s_bvalid ? cfg_bresp : 2'b00;
  assign bid     = '0;
  assign arready = s_ar_rdy;
  assign rvalid  = s_r_act;
  assign rdata   = rmem[s_r_cnt[2:0]];
  assign rlast   = s_r_act && (cfg_early ? (s_r_cnt == 8'd1) : (s_r_cnt == s_r_len));
  assign rresp   = 2'b00;
  assign rid     = '0;

  // Slave: READY one cycle after VALID; WREADY only after AW handshake, dropped after WLAST.
  always @(posedge clk) begin
    if (rst) begin
      s_aw_rdy <= 1'b0; s_w_open <= 1'b0; s_w_rdy <= 1'b0; s_bvalid <= 1'b0;
      s_ar_rdy <= 1'b0; s_r_act <= 1'b0; s_r_cnt <= 8'd0; s_r_len <= 8'd0;
    end else begin
      s_aw_rdy <= awvalid && !s_aw_rdy;
      if (awvalid && s_aw_rdy) s_w_open <= 1'b1;
      if (s_w_open && wvalid && !s_w_rdy) s_w_rdy <= 1'b1;
      if (wvalid && s_w_rdy && wlast) begin
        s_w_rdy <= 1'b0; s_w_open <= 1'b0; s_bvalid <= 1'b1;
      end
      if (s_bvalid && bready) s_bvalid <= 1'b0;
      s_ar_rdy <= arvalid && !s_ar_rdy;
      if (arvalid && s_ar_rdy) begin
        s_r_act <= 1'b1; s_r_cnt <= 8'd0; s_r_len <= arlen;
      end
      if (s_r_act && rready) begin
        s_r_cnt <= s_r_cnt + 8'd1;
        if (s_r_cnt == s_r_len) s_r_act <= 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic clr_mon = 1'b0;
  int cyc = 0, acc_cyc = 0, aw_cyc = 0, w1_cyc = 0, b_cyc = 0, done_cyc = 0;
  int w_beats = 0, r_beats = 0, done_cnt = 0, viol = 0;
  logic [DW-1:0] wcap [8];
  logic [DW-1:0] rcap [8];
  logic [7:0] wlast_cap = 8'd0, rlast_cap = 8'd0;
  logic [7:0] aw_len = 8'd0, ar_len = 8'd0;
  logic [2:0] aw_size = 3'd0;
  logic [1:0] aw_burst = 2'd0;
  logic [AW-1:0] aw_addr = '0;
  logic aw_wait = 1'b0, ar_wait = 1'b0;
  logic [AW-1:0] aw_h_addr = '0, ar_h_addr = '0;
  logic [7:0] aw_h_len = 8'd0, ar_h_len = 8'd0;

  // Monitor: records handshakes, beat data and AxVALID stability.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) acc_cyc <= cyc;
    if (awvalid && awready) begin
      aw_cyc <= cyc; aw_len <= awlen; aw_size <= awsize; aw_burst <= awburst; aw_addr <= awaddr;
    end
    if (bvalid && bready) b_cyc <= cyc;
    if (arvalid && arready) ar_len <= arlen;
    if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (clr_mon) begin
      w_beats <= 0; r_beats <= 0; wlast_cap <= 8'd0; rlast_cap <= 8'd0;
    end else begin
      if (wvalid && wready) begin
        if (w_beats == 0) w1_cyc <= cyc;
        wcap[w_beats[2:0]] <= wdata;
        wlast_cap[w_beats[2:0]] <= wlast;
        w_beats <= w_beats + 1;
      end
      if (rd_valid && rd_ready) begin
        rcap[r_beats[2:0]] <= rd_data;
        rlast_cap[r_beats[2:0]] <= rd_last;
        r_beats <= r_beats + 1;
      end
    end
    if (!rst && aw_wait && (!awvalid || awaddr != aw_h_addr || awlen != aw_h_len)) viol <= viol + 1;
    if (!rst && ar_wait && (!arvalid || araddr != ar_h_addr || arlen != ar_h_len)) viol <= viol + 1;
    aw_wait <= !rst && awvalid && !awready; aw_h_addr <= awaddr; aw_h_len <= awlen;
    ar_wait <= !rst && arvalid && !arready; ar_h_addr <= araddr; ar_h_len <= arlen;
  end

  // ---------------- source / sink drivers ----------------
  logic src_en = 1'b0, snk_en = 1'b0, tog_w = 1'b0, tog_r = 1'b0, ph = 1'b0;

  function automatic logic [DW-1:0] wpat(input int k);
    logic [31:0] w;
    w = 32'hA5A5_0000 + 32'(k);
    return {16{w}};
  endfunction

  // Drivers: present beat w_beats on the source; optionally toggle valid/ready.
  always @(negedge clk) begin
    wr_valid = src_en && (tog_w ? ph : 1'b1);
    wr_data  = wpat(w_beats);
    rd_ready = snk_en && (tog_r ? ph : 1'b1);
    ph = ~ph;
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int d0 = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input logic rnw, input logic [AW-1:0] addr, input logic [7:0] len);
    int i;
    @(negedge clk); clr_mon = 1'b1;
    @(negedge clk); clr_mon = 1'b0;
    d0 = done_cnt;
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_len = len;
    i = 0;
    while (!cmd_ready && i < 50) begin @(negedge clk); i++; end
    if (i >= 50) chk("cmd_accept_timeout", 1'b0, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (!done && i < 300) begin @(negedge clk); i++; end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 8; k++) rmem[k] = {16{32'h3C3C_0000 + 32'(k)}};
    rst = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_len = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_status", {busy, done, resp_err}, 3'b000);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rd_valid, wr_ready}, 7'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1'b1);

    // 1: write len 3, source always valid
    src_en = 1'b1; snk_en = 1'b1; tog_w = 1'b0; tog_r = 1'b0;
    run_cmd(1'b0, 6'h00, 8'd3);
    wait_done("wr4");
    chk("wr4_beats", 32'(w_beats), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("wr4_data%0d", k), wcap[k], wpat(k));
    chk("wr4_wlast", wlast_cap[3:0], 4'b1000);
    chk("wr4_awlen", aw_len, 8'd3);
    chk("wr4_awsize", aw_size, 3'd6);
    chk("wr4_awburst", aw_burst, 2'b01);
    chk("wr4_awaddr", aw_addr, 6'h00);
    chk("wr4_aw_lat", 32'(aw_cyc - acc_cyc), 32'd2);
    chk("wr4_w1_lat", 32'(w1_cyc - acc_cyc), 32'd4);
    chk("wr4_b_to_done", 32'(done_cyc - b_cyc), 32'd1);
    chk("wr4_err", resp_err, 1'b0);

    // 2: read len 3, sink always ready
    run_cmd(1'b1, 6'h00, 8'd3);
    wait_done("rd4");
    chk("rd4_beats", 32'(r_beats), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("rd4_data%0d", k), rcap[k], rmem[k]);
    chk("rd4_rlast", rlast_cap[3:0], 4'b1000);
    chk("rd4_arlen", ar_len, 8'd3);
    chk("rd4_err", resp_err, 1'b0);

    // 3: toggling source valid and sink ready
    tog_w = 1'b1; tog_r = 1'b1;
    run_cmd(1'b0, 6'h00, 8'd3);
    wait_done("wrtog");
    chk("wrtog_beats", 32'(w_beats), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("wrtog_data%0d", k), wcap[k], wpat(k));
    chk("wrtog_wlast", wlast_cap[3:0], 4'b1000);
    run_cmd(1'b1, 6'h00, 8'd3);
    wait_done("rdtog");
    chk("rdtog_beats", 32'(r_beats), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("rdtog_data%0d", k), rcap[k], rmem[k]);
    chk("rdtog_rlast", rlast_cap[3:0], 4'b1000);
    tog_w = 1'b0; tog_r = 1'b0;

    // 4: single-beat bursts
    run_cmd(1'b0, 6'h00, 8'd0);
    wait_done("wr1");
    chk("wr1_beats", 32'(w_beats), 32'd1);
    chk("wr1_wlast", wlast_cap[0], 1'b1);
    chk("wr1_data", wcap[0], wpat(0));
    chk("wr1_awlen", aw_len, 8'd0);
    run_cmd(1'b1, 6'h00, 8'd0);
    wait_done("rd1");
    chk("rd1_beats", 32'(r_beats), 32'd1);
    chk("rd1_rlast", rlast_cap[0], 1'b1);
    chk("rd1_data", rcap[0], rmem[0]);

    // 5: error responses
    cfg_bresp = 2'b10;
    run_cmd(1'b0, 6'h00, 8'd3);
    wait_done("wrerr");
    chk("wrerr_beats", 32'(w_beats), 32'd4);
    chk("wrerr_flag", resp_err, 1'b1);
    repeat (4) @(negedge clk);
    chk("wrerr_sticky", resp_err, 1'b1);
    cfg_bresp = 2'b00;
    run_cmd(1'b1, 6'h00, 8'd3);
    chk("err_clear_on_accept", resp_err, 1'b0);
    wait_done("rdok");
    chk("rdok_err", resp_err, 1'b0);
    cfg_early = 1'b1;
    run_cmd(1'b1, 6'h00, 8'd3);
    wait_done("rderr");
    chk("rderr_beats", 32'(r_beats), 32'd4);
    chk("rderr_flag", resp_err, 1'b1);
    cfg_early = 1'b0;

    // 6: reset during WR_DATA beat 2
    run_cmd(1'b0, 6'h00, 8'd3);
    for (int i = 0; i < 50 && w_beats < 1; i++) @(negedge clk);
    chk("rstmid_in_wdata", 32'(w_beats), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'd0);
    chk("rstmid_busy", busy, 1'b0);
    rst = 1'b0;
    run_cmd(1'b1, 6'h00, 8'd1);
    wait_done("rdpost");
    chk("rdpost_beats", 32'(r_beats), 32'd2);
    chk("rdpost_data1", rcap[1], rmem[1]);

    chk("axvalid_stable", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
